// File: rtl/highest_index_pkg.sv
// Shared types and the priority-search helper for the highest-index scanner.
package highest_index_pkg;

    localparam int MAX_WIDTH = 256;
    localparam int MAX_IDX_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } hs_t;

    // Narrower vectors are zero-extended by the caller, so unused upper bits never win.
    function automatic hs_t highest_set(input logic [MAX_WIDTH-1:0] vec);
        hs_t res;
        res.found = 1'b0;
        res.idx   = {MAX_IDX_W{1'b0}};
        for (int i = 0; i < MAX_WIDTH; i++) begin
            res.found = res.found | vec[i];
            res.idx   = vec[i] ? MAX_IDX_W'(i) : res.idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/highest_index_enc.sv
// Combinational priority encoder: highest set bit, all-zero flag and single-bit flag.
module highest_index_enc
    import highest_index_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             zero,
    output logic             one_hot
);

    hs_t hs_s;

    // Priority search plus the exactly-one-bit test (clearing the lowest bit leaves zero).
    always_comb begin
        hs_s    = highest_set(MAX_WIDTH'(vec));
        idx     = IDX_W'(hs_s.idx);
        zero    = ~hs_s.found;
        one_hot = hs_s.found & ((vec & (vec - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/highest_index_scanner.sv
// Handshaked highest-set-bit scanner: one beat per vector (mode 0) or per set bit (mode 1).
module highest_index_scanner
    import highest_index_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);

    state_t           state_r, next_state_s;
    logic [WIDTH-1:0] rem_r, next_rem_s;
    logic             mode_r, next_mode_s;
    logic [IDX_W-1:0] enc_idx_s;
    logic             enc_zero_s;
    logic             enc_one_hot_s;
    logic             in_hs_s;
    logic             out_hs_s;
    logic [WIDTH-1:0] clr_mask_s;

    highest_index_enc #(.WIDTH(WIDTH)) u_enc (
        .vec     (rem_r),
        .idx     (enc_idx_s),
        .zero    (enc_zero_s),
        .one_hot (enc_one_hot_s)
    );

    // Beat fields come only from the held state; they are forced to zero while idle.
    always_comb begin
        out_valid  = (state_r == EMIT);
        out_idx    = out_valid ? enc_idx_s : {IDX_W{1'b0}};
        out_zero   = out_valid & enc_zero_s;
        out_last   = out_valid & (enc_zero_s | ~mode_r | enc_one_hot_s);
        in_ready   = (state_r == IDLE) | (out_valid & out_ready & out_last);
        in_hs_s    = in_valid & in_ready;
        out_hs_s   = out_valid & out_ready;
        clr_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << enc_idx_s;
    end

    // A new vector always wins: it can only arrive while idle or on the last beat.
    always_comb begin
        next_state_s = state_r;
        next_rem_s   = rem_r;
        next_mode_s  = mode_r;
        if (in_hs_s) begin
            next_state_s = EMIT;
            next_rem_s   = in_vec;
            next_mode_s  = in_mode;
        end else if (out_hs_s) begin
            next_rem_s   = rem_r & ~clr_mask_s;
            next_state_s = out_last ? IDLE : EMIT;
        end else begin
            next_state_s = state_r;
        end
    end

    // State, remaining-vector and mode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rem_r   <= {WIDTH{1'b0}};
            mode_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            rem_r   <= next_rem_s;
            mode_r  <= next_mode_s;
        end
    end

endmodule

// File: tb/tb_highest_index_scanner.sv
// Self-checking bench: directed and random traffic against a beat-list reference model.
module tb_highest_index_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_vec = 8'h00;
    logic       in_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_zero;

    logic       n4_rst_n = 1'b0;
    logic       n4_in_valid = 1'b0;
    logic       n4_in_ready;
    logic [3:0] n4_in_vec = 4'h0;
    logic       n4_out_valid;
    logic [1:0] n4_out_idx;
    logic       n4_out_last;
    logic       n4_out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic       zero;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    highest_index_scanner #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .out_zero(out_zero)
    );

    highest_index_scanner #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(n4_rst_n),
        .in_valid(n4_in_valid), .in_ready(n4_in_ready), .in_vec(n4_in_vec), .in_mode(1'b0),
        .out_valid(n4_out_valid), .out_ready(1'b1), .out_idx(n4_out_idx),
        .out_last(n4_out_last), .out_zero(n4_out_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // floor(log2(v)) for v > 0
    function automatic int top_bit(input int v);
        return $clog2(v + 1) - 1;
    endfunction

    // Expected beats for one accepted vector.
    task automatic push_vector(input logic [7:0] v, input logic m);
        beat_t b;
        int    left;
        left = $countones(v);
        if (v == 8'h00) begin
            b.idx = 3'd0; b.last = 1'b1; b.zero = 1'b1;
            exp_q.push_back(b);
        end else if (!m) begin
            b.idx = 3'(top_bit(int'(v))); b.last = 1'b1; b.zero = 1'b0;
            exp_q.push_back(b);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    b.idx = 3'(i); b.last = (left == 1); b.zero = 1'b0;
                    exp_q.push_back(b);
                    left--;
                end
            end
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model across the edge.
    task automatic step(input logic iv, input logic [7:0] vec, input logic m, input logic ordy);
        logic exp_rdy, ihs, ohs, have;
        in_valid = iv; in_vec = vec; in_mode = m; out_ready = ordy;
        #1;
        have    = (exp_q.size() != 0);
        exp_rdy = !have || (ordy && exp_q[0].last);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(have));
        if (have) begin
            check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            check("out_last", 32'(out_last), 32'(exp_q[0].last));
            check("out_zero", 32'(out_zero), 32'(exp_q[0].zero));
        end
        ihs = iv && exp_rdy;
        ohs = ordy && have;
        @(posedge clk); #1;
        if (ohs) exp_q.delete(0);
        if (ihs) push_vector(vec, m);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
    endtask

    initial begin
        logic [7:0] rv;
        apply_reset();

        // mode 0 single beat, then idle
        step(1'b1, 8'b0010_1100, 1'b0, 1'b1);
        check("t1_idx", 32'(out_idx), 32'd5);
        check("t1_last", 32'(out_last), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_idle_ready", 32'(in_ready), 32'd1);
        check("t1_idle_valid", 32'(out_valid), 32'd0);

        // mode 1 scan 7,2,0
        step(1'b1, 8'b1000_0101, 1'b1, 1'b1);
        check("t2_idx7", 32'(out_idx), 32'd7);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_idx2", 32'(out_idx), 32'd2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_idx0", 32'(out_idx), 32'd0);
        check("t2_last", 32'(out_last), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // zero vector
        step(1'b1, 8'h00, 1'b1, 1'b1);
        check("t3_zero", 32'(out_zero), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // stall for 3 cycles
        step(1'b1, 8'hA0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t4_idx5", 32'(out_idx), 32'd5);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // back-to-back with no bubble
        step(1'b1, 8'h10, 1'b0, 1'b1);
        step(1'b1, 8'h03, 1'b1, 1'b1);
        check("t5_idx1", 32'(out_idx), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // reset mid-scan
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_idx6", 32'(out_idx), 32'd6);
        apply_reset();
        step(1'b1, 8'h01, 1'b1, 1'b1);
        check("t6_idx0", 32'(out_idx), 32'd0);
        check("t6_last", 32'(out_last), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step(1'($urandom_range(0, 1)), rv, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // WIDTH=4 exhaustive mode 0
        n4_rst_n = 1'b0;
        @(posedge clk); #1;
        n4_rst_n = 1'b1;
        for (int v = 0; v < 16; v++) begin
            n4_in_valid = 1'b1; n4_in_vec = 4'(v);
            @(posedge clk); #2;
            check("w4_valid", 32'(n4_out_valid), 32'd1);
            check("w4_idx", 32'(n4_out_idx), (v == 0) ? 32'd0 : 32'(top_bit(v)));
            check("w4_zero", 32'(n4_out_zero), 32'(v == 0));
            check("w4_last", 32'(n4_out_last), 32'd1);
        end
        n4_in_valid = 1'b0;
        @(posedge clk); #2;
        check("w4_idle_valid", 32'(n4_out_valid), 32'd0);
        check("w4_idle_ready", 32'(n4_in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
